// File: rtl/interval_meter_pkg.sv
// Shared types and constants for the interval meter.
package interval_meter_pkg;

  localparam int unsigned IM_DEFAULT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/interval_meter.sv
// Measures the edge distance from start to stop and presents it as a valid/ready result.
// Optional INTERVAL_METER_ABORT_EN adds an abort input that returns RUN/DONE to IDLE.
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int unsigned W = IM_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
`ifdef INTERVAL_METER_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         meas_valid,
  input  logic         meas_ready,
  output logic [W-1:0] meas_cnt,
  output logic         meas_ovf
);

  localparam logic [W-1:0] CNT_MAX = '1;

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;

  logic [W-1:0]   acc_inc;
  logic           acc_hit;

  // Saturating increment; hit means acc+1 has reached the limit.
  assign acc_inc = (acc_q == CNT_MAX) ? CNT_MAX : acc_q + W'(1);
  assign acc_hit = (acc_q >= CNT_MAX - W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          cnt_d   = acc_inc;
          ovf_d   = acc_hit;
          state_d = DONE;
        end else begin
          acc_d   = acc_inc;
        end
      end
      DONE: begin
        // A start on the transfer edge chains straight into the next measurement.
        if (meas_ready) begin
          if (start) begin
            acc_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef INTERVAL_METER_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
    end
`endif

    busy_d  = (state_d == RUN);
    valid_d = (state_d == DONE);
  end

  assign busy       = busy_q;
  assign meas_valid = valid_q;
  assign meas_cnt   = cnt_q;
  assign meas_ovf   = ovf_q;

endmodule

// File: tb/tb_interval_meter.sv
// Directed self-checking bench for interval_meter at W=32 and W=4.
module tb_interval_meter;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, meas_ready;
`ifdef INTERVAL_METER_ABORT_EN
  logic abort;
`endif
  logic        busy32, valid32, ovf32;
  logic [31:0] cnt32;
  logic        busy4, valid4, ovf4;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  interval_meter #(.W(32)) dut32 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
`ifdef INTERVAL_METER_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy32),
    .meas_valid (valid32),
    .meas_ready (meas_ready),
    .meas_cnt   (cnt32),
    .meas_ovf   (ovf32)
  );

  interval_meter #(.W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
`ifdef INTERVAL_METER_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy4),
    .meas_valid (valid4),
    .meas_ready (meas_ready),
    .meas_cnt   (cnt4),
    .meas_ovf   (ovf4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply current inputs across one rising edge, then sample 1 time unit later.
  task automatic step(input logic s, input logic p, input logic r);
    start = s;
    stop = p;
    meas_ready = r;
    @(posedge clk);
    #1;
  endtask

  // start accepted, n-1 counting edges, stop accepted: result n.
  task automatic measure(input int n, input logic r);
    step(1'b1, 1'b0, r);
    for (int i = 1; i < n; i++) step(1'b0, 1'b0, r);
    step(1'b0, 1'b1, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; meas_ready = 1'b0;
`ifdef INTERVAL_METER_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check("reset_busy", {31'd0, busy32}, 32'd0);
    check("reset_valid", {31'd0, valid32}, 32'd0);
    check("reset_cnt", cnt32, 32'd0);
    check("reset_ovf", {31'd0, ovf32}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

    // Basic interval of 5 with consumer ready.
    step(1'b1, 1'b0, 1'b1);
    check("basic_busy", {31'd0, busy32}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    check("basic_no_valid_yet", {31'd0, valid32}, 32'd0);
    step(1'b0, 1'b1, 1'b1);
    check("basic_valid", {31'd0, valid32}, 32'd1);
    check("basic_busy_off", {31'd0, busy32}, 32'd0);
    check("basic_cnt", cnt32, 32'd5);
    check("basic_ovf", {31'd0, ovf32}, 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("basic_valid_one_cycle", {31'd0, valid32}, 32'd0);
    check("basic_idle_busy", {31'd0, busy32}, 32'd0);

    // Backpressure, ignored start in DONE, then back-to-back.
    measure(6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step((i == 2), 1'b0, 1'b0);
      check("bp_valid_hold", {31'd0, valid32}, 32'd1);
      check("bp_cnt_hold", cnt32, 32'd6);
      check("bp_no_restart", {31'd0, busy32}, 32'd0);
    end
    step(1'b1, 1'b0, 1'b1);
    check("b2b_busy", {31'd0, busy32}, 32'd1);
    check("b2b_valid_drop", {31'd0, valid32}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("b2b_cnt", cnt32, 32'd3);
    check("b2b_valid", {31'd0, valid32}, 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("b2b_idle", {31'd0, valid32}, 32'd0);

    // Saturation on the 4-bit instance.
    measure(20, 1'b0);
    check("sat20_cnt4", {28'd0, cnt4}, 32'd15);
    check("sat20_ovf4", {31'd0, ovf4}, 32'd1);
    check("sat20_cnt32", cnt32, 32'd20);
    check("sat20_ovf32", {31'd0, ovf32}, 32'd0);
    step(1'b0, 1'b0, 1'b1);
    measure(15, 1'b0);
    check("sat15_cnt4", {28'd0, cnt4}, 32'd15);
    check("sat15_ovf4", {31'd0, ovf4}, 32'd1);
    check("sat15_ovf32", {31'd0, ovf32}, 32'd0);
    step(1'b0, 1'b0, 1'b1);
    measure(14, 1'b0);
    check("sat14_cnt4", {28'd0, cnt4}, 32'd14);
    check("sat14_ovf4", {31'd0, ovf4}, 32'd0);
    step(1'b0, 1'b0, 1'b1);

    // Ignored events: stray stop, start+stop in IDLE, start in RUN.
    step(1'b0, 1'b1, 1'b0);
    check("ign_stop_idle_busy", {31'd0, busy32}, 32'd0);
    check("ign_stop_idle_valid", {31'd0, valid32}, 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("ign_coincident_run", {31'd0, busy32}, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("ign_start_in_run", {31'd0, busy32}, 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("ign_cnt", cnt32, 32'd3);
    step(1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-RUN after 7 counted cycles.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy32}, 32'd0);
    check("arst_cnt", cnt32, 32'd0);
    check("arst_valid", {31'd0, valid32}, 32'd0);
    #2;
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    check("arst_no_result", {31'd0, valid32}, 32'd0);
    check("arst_idle", {31'd0, busy32}, 32'd0);
    measure(1, 1'b0);
    check("arst_first_n1_cnt", cnt32, 32'd1);
    check("arst_first_n1_valid", {31'd0, valid32}, 32'd1);
    step(1'b0, 1'b0, 1'b1);

`ifdef INTERVAL_METER_ABORT_EN
    // Abort in RUN, then abort with ready in DONE.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    abort = 1'b0;
    check("abort_run_busy", {31'd0, busy32}, 32'd0);
    check("abort_run_valid", {31'd0, valid32}, 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check("abort_run_stop_ignored", {31'd0, valid32}, 32'd0);
    measure(2, 1'b0);
    check("abort_done_valid_pre", {31'd0, valid32}, 32'd1);
    abort = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    abort = 1'b0;
    check("abort_done_valid", {31'd0, valid32}, 32'd0);
    check("abort_done_busy", {31'd0, busy32}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
